// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the sequential ALU.
// Opcodes 0-9 keep the legacy single-cycle ALU encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_SLL   = 4'd2,
    OP_SLT   = 4'd3,
    OP_SLTU  = 4'd4,
    OP_XOR   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_OR    = 4'd8,
    OP_AND   = 4'd9,
    OP_MUL   = 4'd10,
    OP_MULHU = 4'd11,
    OP_DIVU  = 4'd12,
    OP_REMU  = 4'd13,
    OP_UND14 = 4'd14,
    OP_UND15 = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_muldiv(input alu_op_t op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operation request / result handshake bundle for alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;
  logic             out_err;
  logic             flush;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready, flush,
    input  in_ready, out_valid, out_data, out_tag, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready, flush,
    output in_ready, out_valid, out_data, out_tag, out_err
  );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative unit: shift-add multiply / restoring divide, one bit per cycle.
// done/result describe the iteration finishing on the coming edge.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH) + 1;

  // acc holds {hi, lo} product for MUL, {remainder, quotient} for DIV
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   operand_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg, is_div_reg, want_hi_reg;
  logic [WIDTH:0]     sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    shifted = acc_reg[2*WIDTH-1:WIDTH-1];
    diff    = shifted - {1'b0, operand_reg};
    if (is_div_reg) begin
      // divide by zero falls out naturally: every bit compares >= 0
      if (shifted >= {1'b0, operand_reg})
        acc_next = {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
      else
        acc_next = {shifted[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc_reg[WIDTH-1:1]};
    end
  end

  assign result = want_hi_reg ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
  assign done   = busy_reg && (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg     <= '0;
      operand_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      is_div_reg  <= 1'b0;
      want_hi_reg <= 1'b0;
    end else if (abort) begin
      busy_reg <= 1'b0;
      cnt_reg  <= '0;
    end else if (start) begin
      is_div_reg  <= (op == OP_DIVU) || (op == OP_REMU);
      want_hi_reg <= (op == OP_MULHU) || (op == OP_REMU);
      acc_reg     <= ((op == OP_DIVU) || (op == OP_REMU)) ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
      operand_reg <= ((op == OP_DIVU) || (op == OP_REMU)) ? b : a;
      busy_reg    <= 1'b1;
      cnt_reg     <= '0;
    end else if (busy_reg) begin
      acc_reg <= acc_next;
      if (done) begin
        busy_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops resolve on accept, MUL/DIV family
// iterates in alu_muldiv; one result register with valid/ready output.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int SW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             err_reg;
  alu_op_t          op;
  logic             accept, md_op, md_start, md_done;
  logic [WIDTH-1:0] md_result, alu_result;
  logic             alu_err;
  logic [SW-1:0]    shamt;

  assign op       = alu_op_t'(bus.in_op);
  assign md_op    = is_muldiv(op);
  assign shamt    = bus.in_b[SW-1:0];
  assign accept   = bus.in_valid && bus.in_ready && !bus.flush;
  assign md_start = accept && md_op;

  always_comb begin
    alu_result = '0;
    alu_err    = 1'b0;
    case (op)
      OP_ADD:  alu_result = bus.in_a + bus.in_b;
      OP_SUB:  alu_result = bus.in_a - bus.in_b;
      OP_SLL:  alu_result = bus.in_a << shamt;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(bus.in_a) < $signed(bus.in_b)};
      OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, bus.in_a < bus.in_b};
      OP_XOR:  alu_result = bus.in_a ^ bus.in_b;
      OP_SRL:  alu_result = bus.in_a >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(bus.in_a) >>> shamt);
      OP_OR:   alu_result = bus.in_a | bus.in_b;
      OP_AND:  alu_result = bus.in_a & bus.in_b;
      OP_UND14, OP_UND15: alu_err = 1'b1;
      default: alu_result = '0;
    endcase
  end

  alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .abort  (bus.flush),
    .start  (md_start),
    .op     (op),
    .a      (bus.in_a),
    .b      (bus.in_b),
    .done   (md_done),
    .result (md_result)
  );

  // flush outranks both a new accept and an iteration finishing
  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) state_next = md_op ? ST_BUSY : ST_DONE;
        ST_BUSY: if (md_done) state_next = ST_DONE;
        ST_DONE: begin
          if (accept)             state_next = md_op ? ST_BUSY : ST_DONE;
          else if (bus.out_ready) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
      tag_reg  <= '0;
      err_reg  <= 1'b0;
    end else if (!bus.flush) begin
      if (accept) begin
        tag_reg  <= bus.in_tag;
        data_reg <= alu_result;
        err_reg  <= alu_err;
      end else if (state_reg == ST_BUSY && md_done) begin
        data_reg <= md_result;
        err_reg  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_reg == ST_IDLE) || (state_reg == ST_DONE && bus.out_ready);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.out_data  = data_reg;
  assign bus.out_tag   = tag_reg;
  assign bus.out_err   = err_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized and directed checks of alu_seq against an arithmetic reference model.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  alu_seq_if #(.WIDTH(32), .TAG_W(4)) bus ();

  alu_seq #(.WIDTH(32), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    int sh;
    sh = int'(b % 32);
    p  = 64'(a) * 64'(b);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a << sh;
      3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4:  return (a < b) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return a >> sh;
      7:  return (a >> sh) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      8:  return a | b;
      9:  return a & b;
      10: return p[31:0];
      11: return p[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_latency(input int op);
    return (op >= 10 && op <= 13) ? 33 : 1;
  endfunction

  // Offer one op from IDLE with out_ready=1 and wait for its result.
  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                        output logic [31:0] d, output logic [3:0] t, output logic e,
                        output int lat, output int rdy_seen);
    @(negedge clk);
    bus.in_op = 4'(op); bus.in_a = a; bus.in_b = b; bus.in_tag = tag;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1; rdy_seen = 0;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) lat = -1;
    d = bus.out_data; t = bus.out_tag; e = bus.out_err;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 4'd0; bus.in_a = '0; bus.in_b = '0; bus.in_tag = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", bus.out_data); end
    checks++; if (bus.out_tag !== 4'h0) begin errors++; $display("FAIL reset_tag got %h want 0", bus.out_tag); end
    checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.out_err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", bus.in_ready); end
    $display("reset: valid=%b data=%h ready=%b", bus.out_valid, bus.out_data, bus.in_ready);
  endtask

  typedef struct {
    int          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  task automatic test_directed;
    vec_t v[11] = '{
      '{0,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0},
      '{7,  32'h8000_0000, 32'h24,        32'hF800_0000, 1'b0},
      '{3,  32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0},
      '{4,  32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0},
      '{11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0},
      '{12, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0},
      '{13, 32'd7,         32'd0,         32'd7,         1'b0},
      '{12, 32'd100,       32'd7,         32'd14,        1'b0},
      '{13, 32'd100,       32'd7,         32'd2,         1'b0},
      '{15, 32'd5,         32'd6,         32'h0,         1'b1},
      '{10, 32'd3,         32'd5,         32'd15,        1'b0}
    };
    logic [31:0] d; logic [3:0] t; logic e; int lat, rdy;
    for (int i = 0; i < 11; i++) begin
      logic [3:0] tag;
      int exp_lat;
      tag = 4'(i + 3);
      exp_lat = (v[i].op >= 10 && v[i].op <= 13) ? 33 : 1;
      run_op(v[i].op, v[i].a, v[i].b, tag, d, t, e, lat, rdy);
      $display("directed op=%0d a=%h b=%h -> data=%h tag=%0d err=%b lat=%0d", v[i].op, v[i].a, v[i].b, d, t, e, lat);
      checks++; if (d !== v[i].exp) begin errors++; $display("FAIL dir_data[%0d] got %h want %h", i, d, v[i].exp); end
      checks++; if (t !== tag) begin errors++; $display("FAIL dir_tag[%0d] got %0d want %0d", i, t, tag); end
      checks++; if (e !== v[i].err) begin errors++; $display("FAIL dir_err[%0d] got %b want %b", i, e, v[i].err); end
      checks++; if (lat != exp_lat) begin errors++; $display("FAIL dir_latency[%0d] got %0d want %0d", i, lat, exp_lat); end
      checks++; if (rdy != 0) begin errors++; $display("FAIL dir_busy_ready[%0d] got %0d want 0", i, rdy); end
    end
  endtask

  task automatic test_random;
    logic [31:0] d; logic [3:0] t; logic e; int lat, rdy;
    for (int i = 0; i < 40; i++) begin
      int op;
      logic [31:0] a, b;
      logic [3:0] tag;
      op  = int'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      tag = 4'($urandom);
      if (i % 5 == 1) b = 32'($urandom_range(0, 9));
      run_op(op, a, b, tag, d, t, e, lat, rdy);
      $display("random op=%0d a=%h b=%h -> data=%h tag=%0d err=%b lat=%0d", op, a, b, d, t, e, lat);
      checks++; if (d !== ref_result(op, a, b)) begin errors++; $display("FAIL rnd_data[%0d] got %h want %h", i, d, ref_result(op, a, b)); end
      checks++; if (t !== tag) begin errors++; $display("FAIL rnd_tag[%0d] got %0d want %0d", i, t, tag); end
      checks++; if (e !== (op >= 14)) begin errors++; $display("FAIL rnd_err[%0d] got %b want %b", i, e, op >= 14); end
      checks++; if (lat != ref_latency(op)) begin errors++; $display("FAIL rnd_latency[%0d] got %0d want %0d", i, lat, ref_latency(op)); end
      checks++; if (rdy != 0) begin errors++; $display("FAIL rnd_busy_ready[%0d] got %0d want 0", i, rdy); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] av[6], bv[6], ev[6];
    for (int k = 0; k < 6; k++) begin
      av[k] = $urandom; bv[k] = $urandom; ev[k] = ref_result(0, av[k], bv[k]);
    end
    @(negedge clk);
    bus.in_op = 4'd0; bus.in_a = av[0]; bus.in_b = bv[0]; bus.in_tag = 4'd0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_a = av[1]; bus.in_b = bv[1]; bus.in_tag = 4'd1;
    for (int s = 0; s < 3; s++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== ev[0] || bus.out_tag !== 4'd0)
        begin errors++; $display("FAIL b2b_stall[%0d] got v=%b %h/%0d want v=1 %h/0", s, bus.out_valid, bus.out_data, bus.out_tag, ev[0]); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready[%0d] got %b want 0", s, bus.in_ready); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      bus.in_a = av[k]; bus.in_b = bv[k]; bus.in_tag = 4'(k);
      @(negedge clk);
      $display("b2b result %0d data=%h tag=%0d", k, bus.out_data, bus.out_tag);
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== ev[k] || bus.out_tag !== 4'(k))
        begin errors++; $display("FAIL b2b_stream[%0d] got v=%b %h/%0d want v=1 %h/%0d", k, bus.out_valid, bus.out_data, bus.out_tag, ev[k], k); end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush;
    logic [31:0] d; logic [3:0] t; logic e; int lat, rdy, seen;
    @(negedge clk);
    bus.in_op = 4'd10; bus.in_a = 32'd1234; bus.in_b = 32'd5678; bus.in_tag = 4'd9;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle got %b want 1", bus.in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_mul_valid got %0d want 0", seen); end
    run_op(0, 32'd20, 32'd22, 4'd5, d, t, e, lat, rdy);
    $display("after flush ADD data=%h tag=%0d", d, t);
    checks++; if (d !== 32'd42 || t !== 4'd5 || lat != 1) begin errors++; $display("FAIL flush_next_add got %h/%0d/%0d want 2a/5/1", d, t, lat); end
    // flush while a result is held
    @(negedge clk);
    bus.in_op = 4'd5; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_held_pre got %b want 1", bus.out_valid); end
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_held got %b want 0", bus.out_valid); end
    // flush wins over a simultaneous accept
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_vs_accept got %b want 0", bus.out_valid); end
  endtask

  task automatic test_rst_mid;
    logic [31:0] d; logic [3:0] t; logic e; int lat, rdy, seen;
    @(negedge clk);
    bus.in_op = 4'd11; bus.in_a = 32'hDEAD_BEEF; bus.in_b = 32'h1234_5678; bus.in_tag = 4'd7;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (bus.out_tag !== 4'd0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_state got tag=%0d ready=%b want 0/1", bus.out_tag, bus.in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_valid got %0d want 0", seen); end
    run_op(0, 32'hFFFF_FFF0, 32'h20, 4'd2, d, t, e, lat, rdy);
    $display("after rst ADD data=%h tag=%0d", d, t);
    checks++; if (d !== 32'h10 || t !== 4'd2 || e !== 1'b0) begin errors++; $display("FAIL rst_mid_next_add got %h/%0d/%b want 10/2/0", d, t, e); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 SHALL have parameter TAG_W, default 4, width of the transaction tag echoed with each result.
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation offered.
REQ-006 SHALL have port in_ready  output  1  operation accepted when in_valid && in_ready at a clk edge.
REQ-007 SHALL have port in_op  input  4  opcode.
REQ-008 SHALL have ports in_a and in_b  input  WIDTH  operands.
REQ-009 SHALL have port in_tag  input  TAG_W  caller tag.
REQ-010 SHALL have port out_valid  output  1  result held.
REQ-011 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready at a clk edge.
REQ-012 SHALL have port out_data  output  WIDTH  result.
REQ-013 SHALL have port out_tag  output  TAG_W  tag of the accepted operation.
REQ-014 SHALL have port out_err  output  1  high with result when opcode is undefined.
REQ-015 SHALL have port flush  input  1  synchronous abort of any in-flight or held operation.

Function
REQ-016 SHALL decode opcodes 0-9 as ADD, SUB, SLL, SLT (signed), SLTU, XOR, SRL, SRA, OR, AND with the existing ALU encoding.
REQ-017 SHALL add opcodes 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU.
REQ-018 SHALL treat opcodes 14, 15 as undefined: out_data 0, out_err 1, latency 1.
REQ-019 SHALL use only in_b[log2(WIDTH)-1:0] as shift amount; SRA sign-extends in_a.
REQ-020 SHALL produce SLT/SLTU results zero-extended to WIDTH (value 0 or 1); ADD/SUB/MUL wrap modulo 2^WIDTH.
REQ-021 SHALL implement states IDLE, BUSY, DONE; IDLE->DONE on accepting opcode 0-9/14/15, IDLE->BUSY on 10-13, BUSY->DONE after WIDTH iteration cycles, DONE->IDLE on out_ready with no new accept.
REQ-022 SHALL assert out_valid exactly in DONE; single-cycle ops: out_valid 1 cycle after accept; MUL/MULHU/DIVU/REMU: out_valid WIDTH+1 cycles after accept.
REQ-023 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready), giving one result per cycle for back-to-back single-cycle ops.
REQ-024 SHALL, on accept in DONE with out_ready, replace the result the same edge (DONE->DONE or DONE->BUSY).
REQ-025 SHALL hold out_data, out_tag, out_err stable while out_valid && !out_ready.
REQ-026 SHALL compute MUL/MULHU by shift-add over a 2*WIDTH product, one bit per cycle.
REQ-027 SHALL compute DIVU/REMU by restoring division, one quotient bit per cycle.
REQ-028 SHALL return DIVU by zero = all ones and REMU by zero = in_a, still taking WIDTH+1 cycles.
REQ-029 SHALL ignore in_valid while BUSY (in_ready 0).
REQ-030 SHALL, on flush, go to IDLE next edge, drop out_valid, discard any result; flush has priority over accept and completion in the same cycle.

Reset
REQ-031 SHALL on rst go to IDLE with out_valid 0, out_data 0, out_tag 0, out_err 0, iteration counter 0, in_ready 1 after release.
REQ-032 SHALL abandon any BUSY operation on rst mid-operation; no result is emitted for it.

Structure
REQ-033 SHALL place opcode constants/enum (alu_op_t) and state enum in shared package alu_pkg.
REQ-034 SHALL contain one sub-module alu_muldiv (iterative multiplier/divider with start, done, result) and combinational single-cycle logic in alu_seq.

Verification
REQ-035 SHALL cover: WIDTH=32, ADD 0xFFFFFFFF+1, tag 3, out_ready=1 -> out_data 0, out_tag 3, out_valid 1 cycle after accept.
REQ-036 SHALL cover: SRA in_a 0x80000000, in_b 0x24 -> shift 4, out_data 0xF8000000; SLT -1 vs 1 -> 1, SLTU -> 0.
REQ-037 SHALL cover: MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE after 33 cycles, in_ready 0 throughout BUSY.
REQ-038 SHALL cover: DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIVU 100/7 -> 14, REMU -> 2.
REQ-039 SHALL cover: back-to-back ADDs with out_ready held 0 for 3 cycles -> result and tag stable, no accept, then one result per cycle.
REQ-040 SHALL cover: flush and rst asserted mid-MUL -> no out_valid, IDLE, next ADD correct; opcode 15 -> out_data 0, out_err 1.
